nexys_starship_lm: RTL and testbench

Left-monster state machine for the Nexys Starship game. It sits between the PRNG (`left_random`) and the top-level game-over aggregation, and it feeds the VGA block. On each game tick it may spawn a monster at the left room. The player must raise the left shield before a countdown expires, then hold it until the monster leaves. If the countdown expires, the block raises a sticky `left_gameover` that the top ORs into `gameover_ctrl`.

---
 rtl/nexys_starship_lm_pkg.sv | 15 +
 rtl/nexys_starship_lm_if.sv | 28 ++
 rtl/nexys_starship_tick_gen.sv | 17 +
 rtl/nexys_starship_lm.sv | 101 ++++++++++
 tb/tb_nexys_starship_lm.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/nexys_starship_lm_pkg.sv
// Shared definitions for the Nexys Starship monster blocks: one-hot state
// encodings and default countdown lengths.
package nexys_starship_lm_pkg;

  typedef enum logic [3:0] {
    LM_INIT  = 4'b0001,
    LM_EMPTY = 4'b0010,
    LM_UNSH  = 4'b0100,
    LM_SHLD  = 4'b1000
  } lm_state_t;

  localparam int DEF_SHIELD_TICKS = 5;
  localparam int DEF_HOLD_TICKS   = 3;

endpackage

// File: rtl/nexys_starship_lm_if.sv
// Signal bundle between the game top and the left-monster block.
// The master side is the game top, which drives the controls and reads the status.
interface nexys_starship_lm_if;
  logic       timer_clk;
  logic       play_flag;
  logic       gameover_ctrl;
  logic       left_random;
  logic       l_shield;
  logic       q_LM_Init;
  logic       q_LM_Empty;
  logic       q_LM_Unshielded;
  logic       q_LM_Shielded;
  logic       left_monster;
  logic       left_gameover;
  logic [3:0] ticks_left;

  modport master (
    output timer_clk, play_flag, gameover_ctrl, left_random, l_shield,
    input  q_LM_Init, q_LM_Empty, q_LM_Unshielded, q_LM_Shielded,
    input  left_monster, left_gameover, ticks_left
  );

  modport slave (
    input  timer_clk, play_flag, gameover_ctrl, left_random, l_shield,
    output q_LM_Init, q_LM_Empty, q_LM_Unshielded, q_LM_Shielded,
    output left_monster, left_gameover, ticks_left
  );
endinterface

// File: rtl/nexys_starship_tick_gen.sv
// Rising-edge detector on the divided timer level; tick is one Clk wide.
// timer_clk is sampled as data so the design stays in the Clk domain.
module nexys_starship_tick_gen (
  input  logic Clk,
  input  logic Reset,
  input  logic timer_clk,
  output logic tick
);
  logic timer_clk_d;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) timer_clk_d <= 1'b0;
    else       timer_clk_d <= timer_clk;
  end

  assign tick = timer_clk & ~timer_clk_d;
endmodule

// File: rtl/nexys_starship_lm.sv
// Left-monster state machine: spawns on a tick, counts down to a loss unless
// shielded, and repels the monster once the shield has been held long enough.
module nexys_starship_lm
  import nexys_starship_lm_pkg::*;
#(
  parameter int SHIELD_TICKS = DEF_SHIELD_TICKS,
  parameter int HOLD_TICKS   = DEF_HOLD_TICKS
) (
  input logic               Clk,
  input logic               Reset,
  nexys_starship_lm_if.slave bus
);
  localparam logic [3:0] SHIELD_CNT = 4'(SHIELD_TICKS);
  localparam logic [3:0] HOLD_CNT   = 4'(HOLD_TICKS);

  logic       tick;
  lm_state_t  state_reg, state_next;
  logic [3:0] cnt_reg, cnt_next;
  logic       gameover_reg, gameover_next;

  nexys_starship_tick_gen u_tick_gen (
    .Clk       (Clk),
    .Reset     (Reset),
    .timer_clk (bus.timer_clk),
    .tick      (tick)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_reg    <= LM_INIT;
      cnt_reg      <= 4'd0;
      gameover_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      gameover_reg <= gameover_next;
    end
  end

  // Abort (global game-over or leaving Play) outranks every in-state event.
  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    gameover_next = gameover_reg;
    case (state_reg)
      LM_INIT: begin
        if (bus.play_flag && !bus.gameover_ctrl && !gameover_reg)
          state_next = LM_EMPTY;
      end
      LM_EMPTY: begin
        if (bus.gameover_ctrl || !bus.play_flag) begin
          state_next = LM_INIT;
        end else if (tick && bus.left_random) begin
          state_next = LM_UNSH;
          cnt_next   = SHIELD_CNT;
        end
      end
      LM_UNSH: begin
        if (bus.gameover_ctrl || !bus.play_flag) begin
          state_next = LM_INIT;
          cnt_next   = 4'd0;
        end else if (bus.l_shield) begin
          state_next = LM_SHLD;
          cnt_next   = HOLD_CNT;
        end else if (tick && cnt_reg == 4'd1) begin
          state_next    = LM_INIT;
          cnt_next      = 4'd0;
          gameover_next = 1'b1;
        end else if (tick && cnt_reg > 4'd1) begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      LM_SHLD: begin
        if (bus.gameover_ctrl || !bus.play_flag) begin
          state_next = LM_INIT;
          cnt_next   = 4'd0;
        end else if (!bus.l_shield) begin
          state_next = LM_UNSH;
          cnt_next   = SHIELD_CNT;
        end else if (tick && cnt_reg == 4'd1) begin
          state_next = LM_EMPTY;
          cnt_next   = 4'd0;
        end else if (tick && cnt_reg > 4'd1) begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      default: begin
        state_next = LM_INIT;
        cnt_next   = 4'd0;
      end
    endcase
  end

  assign bus.q_LM_Init       = (state_reg == LM_INIT);
  assign bus.q_LM_Empty      = (state_reg == LM_EMPTY);
  assign bus.q_LM_Unshielded = (state_reg == LM_UNSH);
  assign bus.q_LM_Shielded   = (state_reg == LM_SHLD);
  assign bus.left_monster    = bus.q_LM_Unshielded | bus.q_LM_Shielded;
  assign bus.left_gameover   = gameover_reg;
  assign bus.ticks_left      = bus.left_monster ? cnt_reg : 4'd0;
endmodule

// File: tb/tb_nexys_starship_lm.sv
// Scoreboard bench for nexys_starship_lm: stimulus pushes predictions from a
// behavioural model, a monitor pops and compares after each Clk edge.
module tb_nexys_starship_lm;
  localparam int S = 5;
  localparam int H = 3;

  logic Clk = 1'b0;
  logic Reset = 1'b1;
  always #5 Clk = ~Clk;

  nexys_starship_lm_if bus ();

  nexys_starship_lm #(.SHIELD_TICKS(S), .HOLD_TICKS(H)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  typedef struct {
    logic [3:0] st;   // {shielded, unshielded, empty, init}
    logic       mon;
    logic       go;
    logic [3:0] tl;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int txn = 0;

  // Behavioural model of the game rules.
  bit m_active, m_monster, m_guarded, m_lost, m_prev_tc;
  int m_remaining;
  bit in_play, in_goc, in_rnd, in_sh;

  function automatic exp_t predict();
    exp_t e;
    e.st  = {m_monster && m_guarded, m_monster && !m_guarded,
             m_active && !m_monster, !m_active};
    e.mon = m_monster;
    e.go  = m_lost;
    e.tl  = m_monster ? 4'(m_remaining) : 4'd0;
    return e;
  endfunction

  task automatic model_update(input bit rst_v, input bit tc);
    bit tk;
    if (rst_v) begin
      m_active = 0; m_monster = 0; m_guarded = 0; m_lost = 0;
      m_prev_tc = 0; m_remaining = 0;
      return;
    end
    tk = tc && !m_prev_tc;
    m_prev_tc = tc;
    if (!m_active) begin
      if (in_play && !in_goc && !m_lost) m_active = 1;
    end else if (in_goc || !in_play) begin
      m_active = 0; m_monster = 0; m_remaining = 0;
    end else if (!m_monster) begin
      if (tk && in_rnd) begin
        m_monster = 1; m_guarded = 0; m_remaining = S;
      end
    end else if (!m_guarded) begin
      if (in_sh) begin
        m_guarded = 1; m_remaining = H;
      end else if (tk) begin
        m_remaining--;
        if (m_remaining == 0) begin
          m_lost = 1; m_active = 0; m_monster = 0;
        end
      end
    end else begin
      if (!in_sh) begin
        m_guarded = 0; m_remaining = S;
      end else if (tk) begin
        m_remaining--;
        if (m_remaining == 0) m_monster = 0;
      end
    end
  endtask

  task automatic step(input bit rst_v, input bit tc);
    @(negedge Clk);
    Reset             = rst_v;
    bus.timer_clk     = tc;
    bus.play_flag     = in_play;
    bus.gameover_ctrl = in_goc;
    bus.left_random   = in_rnd;
    bus.l_shield      = in_sh;
    model_update(rst_v, tc);
    sb.push_back(predict());
  endtask

  task automatic do_tick(input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b0, 1'b1);
      step(1'b0, 1'b0);
    end
  endtask

  task automatic check_async_reset(input string tag);
    @(posedge Clk);
    #3;
    Reset = 1'b1;
    #1;
    checks++;
    if ({bus.q_LM_Shielded, bus.q_LM_Unshielded, bus.q_LM_Empty, bus.q_LM_Init} !== 4'b0001 ||
        bus.left_monster !== 1'b0 || bus.left_gameover !== 1'b0 || bus.ticks_left !== 4'd0) begin
      errors++;
      $display("FAIL %s: st=%b mon=%b go=%b tl=%0d, required st=0001 mon=0 go=0 tl=0",
               tag, {bus.q_LM_Shielded, bus.q_LM_Unshielded, bus.q_LM_Empty, bus.q_LM_Init},
               bus.left_monster, bus.left_gameover, bus.ticks_left);
    end else begin
      $display("%s: outputs at reset values before next Clk edge", tag);
    end
  endtask

  // Monitor: one comparison set per Clk edge for which a prediction exists.
  initial begin
    exp_t e;
    logic [3:0] st;
    forever begin
      @(posedge Clk);
      #1;
      if (sb.size() > 0) begin
        e  = sb.pop_front();
        st = {bus.q_LM_Shielded, bus.q_LM_Unshielded, bus.q_LM_Empty, bus.q_LM_Init};
        txn++;
        $display("txn %0d: st=%b mon=%b go=%b tl=%0d (exp st=%b mon=%b go=%b tl=%0d)",
                 txn, st, bus.left_monster, bus.left_gameover, bus.ticks_left,
                 e.st, e.mon, e.go, e.tl);
        checks++;
        if (st !== e.st) begin
          errors++;
          $display("FAIL state txn %0d: got %b required %b", txn, st, e.st);
        end
        checks++;
        if (bus.left_monster !== e.mon) begin
          errors++;
          $display("FAIL left_monster txn %0d: got %b required %b", txn, bus.left_monster, e.mon);
        end
        checks++;
        if (bus.left_gameover !== e.go) begin
          errors++;
          $display("FAIL left_gameover txn %0d: got %b required %b", txn, bus.left_gameover, e.go);
        end
        checks++;
        if (bus.ticks_left !== e.tl) begin
          errors++;
          $display("FAIL ticks_left txn %0d: got %0d required %0d", txn, bus.ticks_left, e.tl);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.timer_clk = 0; bus.play_flag = 0; bus.gameover_ctrl = 0;
    bus.left_random = 0; bus.l_shield = 0;
    in_play = 0; in_goc = 0; in_rnd = 0; in_sh = 0;

    // Reset, then idle in Play with no spawns.
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    in_play = 1;
    step(1'b0, 1'b0);
    do_tick(10);

    // Loss: spawn then let the countdown expire; flag stays sticky.
    in_rnd = 1; do_tick(1);
    in_rnd = 0; do_tick(S);
    do_tick(3);
    check_async_reset("async_reset_after_loss");
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);

    // Repel: shield after two ticks, hold for the full hold count.
    in_rnd = 1; do_tick(1);
    in_rnd = 0; do_tick(2);
    in_sh = 1; step(1'b0, 1'b0);
    do_tick(H);
    step(1'b0, 1'b0);

    // Shield drop mid-hold, then raise on the same Clk as the last tick.
    in_sh = 0; in_rnd = 1; do_tick(1);
    in_rnd = 0; in_sh = 1; step(1'b0, 1'b0);
    do_tick(1);
    in_sh = 0; step(1'b0, 1'b0);
    do_tick(S - 1);
    in_sh = 1; do_tick(1);

    // Global game-over while shielded.
    in_goc = 1; step(1'b0, 1'b0);
    do_tick(3);
    in_goc = 0; step(1'b0, 1'b0);

    // Async reset while unshielded.
    in_sh = 0; in_rnd = 1; do_tick(1);
    in_rnd = 0; do_tick(1);
    check_async_reset("async_reset_unshielded");
    step(1'b1, 1'b0);

    // Randomized phase.
    begin
      bit tc = 0;
      for (int i = 0; i < 600; i++) begin
        if ($urandom_range(0, 2) == 0) tc = ~tc;
        in_play = ($urandom_range(0, 31) != 0);
        in_goc  = ($urandom_range(0, 63) == 0);
        in_rnd  = $urandom_range(0, 1) == 1;
        if ($urandom_range(0, 5) == 0) in_sh = ~in_sh;
        step($urandom_range(0, 99) == 0, tc);
      end
    end

    @(posedge Clk);
    #2;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d predictions left, required 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
